// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                FSM state encodings, the all-zero NOP word and the even
//                parity helper used when IMEM_PARITY_EN is defined.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package imem_pkg;

    // FSM encodings; the numeric values are visible on the state port
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    // Widest instruction word the helpers below accept
    localparam int c_PAR_MAX_W = 64;

    // All-zero word returned for faulted fetches; sliced to DATA_W by users
    localparam logic [c_PAR_MAX_W-1:0] c_NOP_WORD = '0;

    // Even parity bit: makes the XOR over data plus parity bit equal zero.
    // Callers zero-extend their word, which does not change the result.
    function automatic logic even_parity(input logic [c_PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ram
//  Description : DEPTH x WIDTH instruction array with one synchronous write
//                port and one registered read port. The array and the read
//                register are never reset; the fetch unit masks the read
//                data until a real response has been produced.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module imem_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Program-load writes
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read; holds its value when no read is issued so a stalled
    // response stays stable
    always_ff @(posedge clk) begin
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_unit
//  Description : Loadable instruction store. A sequential program-load port
//                fills the array, then PC fetches are served over a
//                valid/ready handshake with one cycle of read latency.
//                Fetches at or beyond the loaded program size return a NOP
//                and raise instr_fault.
//  Options     : IMEM_PARITY_EN - store an even parity bit per word and
//                report mismatches on instr_parity_err.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              load_overflow,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_ready,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_fault,
`ifdef IMEM_PARITY_EN
    output logic              instr_parity_err,
`endif
    output logic [1:0]        state
);

    localparam int c_RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
    localparam int c_PAR_W = 1;
`else
    localparam int c_PAR_W = 0;
`endif
    localparam int c_RAM_W = DATA_W + c_PAR_W;

    localparam logic [ADDR_W:0]   c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] c_NOP       = c_NOP_WORD[DATA_W-1:0];

    logic [1:0]         r_state;
    logic [ADDR_W:0]    r_ptr;          // load pointer, doubles as program size
    logic               r_overflow;
    logic               r_instr_valid;
    logic               r_fault;
    logic               r_zero;         // response data must read as NOP

    logic               w_load_st;
    logic               w_run_st;
    logic               w_ptr_full;
    logic               w_we;
    logic               w_accept;
    logic               w_fault;
    logic               w_re;
    logic [c_RAM_W-1:0] w_wdata;
    logic [c_RAM_W-1:0] w_rdata;

    assign w_load_st  = (r_state == c_ST_LOAD);
    assign w_run_st   = (r_state == c_ST_RUN);
    assign w_ptr_full = (r_ptr == c_DEPTH_CNT);

    // A restart in the same cycle wins over the data beat, so that word is dropped
    assign w_we = w_load_st && !load_start && load_valid && !w_ptr_full;

    assign pc_ready = w_run_st && (!r_instr_valid || instr_ready);
    assign w_accept = pc_valid && pc_ready;

    // Unsigned compare against the program size; the DEPTH bound keeps
    // out-of-array addresses away from the RAM even if the size were stale
    assign w_fault = !({1'b0, pc} < r_ptr) || !({1'b0, pc} < c_DEPTH_CNT);
    assign w_re    = w_accept && !w_fault;

`ifdef IMEM_PARITY_EN
    logic [c_PAR_MAX_W-1:0] w_par_in;
    logic [c_PAR_MAX_W-1:0] w_par_chk;
    assign w_par_in  = c_PAR_MAX_W'(load_data);
    assign w_par_chk = c_PAR_MAX_W'(w_rdata[DATA_W-1:0]);
    assign w_wdata   = {even_parity(w_par_in), load_data};
    // Only a real, non-faulted response can report a parity error
    assign instr_parity_err = !r_zero && (even_parity(w_par_chk) != w_rdata[DATA_W]);
`else
    assign w_wdata = load_data;
`endif

    imem_ram #(
        .WIDTH (c_RAM_W),
        .DEPTH (DEPTH),
        .AW    (c_RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_ptr[c_RAM_AW-1:0]),
        .wdata (w_wdata),
        .re    (w_re),
        .raddr (pc[c_RAM_AW-1:0]),
        .rdata (w_rdata)
    );

    // Mode FSM together with the load pointer and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (load_start) begin
                        r_state    <= c_ST_LOAD;
                        r_ptr      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                c_ST_LOAD: begin
                    if (load_start) begin
                        r_ptr      <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        if (load_valid) begin
                            if (w_ptr_full) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_ptr <= r_ptr + c_CNT_ONE;
                            end
                        end
                        if (load_done) begin
                            r_state <= c_ST_RUN;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (load_start) begin
                        r_state    <= c_ST_LOAD;
                        r_ptr      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Response handshake: a restart drops any pending response, otherwise a
    // new accept refills the slot and a consumed response empties it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_zero        <= 1'b1;
        end else if (w_run_st && load_start) begin
            r_instr_valid <= 1'b0;
        end else if (w_accept) begin
            r_instr_valid <= 1'b1;
            r_fault       <= w_fault;
            r_zero        <= w_fault;
        end else if (instr_ready) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign instruction   = r_zero ? c_NOP : w_rdata[DATA_W-1:0];
    assign instr_fault   = r_fault;
    assign instr_valid   = r_instr_valid;
    assign load_count    = r_ptr;
    assign load_overflow = r_overflow;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_unit
//  Description : Directed self-checking bench for imem_fetch_unit. A default
//                instance (DEPTH=256) covers load, fetch, fault, stall and
//                reset scenarios; a DEPTH=4 instance covers load overflow.
//                IMEM_PARITY_EN additionally exercises the parity check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start, load_valid, load_done;
    logic [7:0] load_data;
    logic [8:0] load_count;
    logic       load_overflow;
    logic       pc_valid;
    logic [7:0] pc;
    logic       pc_ready, instr_valid, instr_ready, instr_fault;
    logic [7:0] instruction;
    logic [1:0] state;
`ifdef IMEM_PARITY_EN
    logic       instr_parity_err;
    logic       d4_parity_err;
`endif

    logic       d4_load_start, d4_load_valid, d4_load_done;
    logic [7:0] d4_load_data;
    logic [8:0] d4_load_count;
    logic       d4_load_overflow;
    logic       d4_pc_valid;
    logic [7:0] d4_pc;
    logic       d4_pc_ready, d4_instr_valid, d4_instr_fault;
    logic [7:0] d4_instruction;
    logic [1:0] d4_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_fetch_unit #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_done     (load_done),
        .load_count    (load_count),
        .load_overflow (load_overflow),
        .pc_valid      (pc_valid),
        .pc            (pc),
        .pc_ready      (pc_ready),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .instr_fault   (instr_fault),
`ifdef IMEM_PARITY_EN
        .instr_parity_err (instr_parity_err),
`endif
        .state         (state)
    );

    imem_fetch_unit #(.DATA_W(8), .ADDR_W(8), .DEPTH(4)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .load_start    (d4_load_start),
        .load_valid    (d4_load_valid),
        .load_data     (d4_load_data),
        .load_done     (d4_load_done),
        .load_count    (d4_load_count),
        .load_overflow (d4_load_overflow),
        .pc_valid      (d4_pc_valid),
        .pc            (d4_pc),
        .pc_ready      (d4_pc_ready),
        .instr_valid   (d4_instr_valid),
        .instr_ready   (1'b1),
        .instruction   (d4_instruction),
        .instr_fault   (d4_instr_fault),
`ifdef IMEM_PARITY_EN
        .instr_parity_err (d4_parity_err),
`endif
        .state         (d4_state)
    );

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_start = 0; load_valid = 0; load_done = 0; load_data = 0;
        pc_valid = 0; pc = 0; instr_ready = 0;
        d4_load_start = 0; d4_load_valid = 0; d4_load_done = 0; d4_load_data = 0;
        d4_pc_valid = 0; d4_pc = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", load_count); end
        checks++; if (load_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", load_overflow); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL reset_instr got %h exp 00", instruction); end
        checks++; if (instr_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", instr_fault); end
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL reset_pc_ready got %b exp 0", pc_ready); end
    endtask

    task automatic test_load_and_fetch();
        logic [7:0] words [3];
        words[0] = 8'h88; words[1] = 8'h38; words[2] = 8'h58;
        load_start = 1; tick(); load_start = 0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL load_state got %0d exp 1", state); end
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_data = words[i]; tick();
        end
        load_valid = 0; load_done = 1; tick(); load_done = 0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL run_state got %0d exp 2", state); end
        checks++; if (load_count !== 9'd3) begin errors++; $display("FAIL load_count got %0d exp 3", load_count); end
        instr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            pc_valid = 1; pc = 8'(i);
            #1;
            checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL b2b_pc_ready[%0d] got %b exp 1", i, pc_ready); end
            tick();
            checks++; if (instr_valid !== 1'b1 || instruction !== words[i] || instr_fault !== 1'b0)
                begin errors++; $display("FAIL b2b_fetch[%0d] got v=%b d=%h f=%b exp v=1 d=%h f=0", i, instr_valid, instruction, instr_fault, words[i]); end
        end
        pc_valid = 0; tick();
        checks++; if (instr_valid !== 1'b0 || instruction !== 8'h58)
            begin errors++; $display("FAIL drain got v=%b d=%h exp v=0 d=58", instr_valid, instruction); end
    endtask

    task automatic test_fault();
        logic [7:0] addrs [2];
        addrs[0] = 8'h03; addrs[1] = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            pc_valid = 1; pc = addrs[i]; tick();
            checks++; if (instr_valid !== 1'b1 || instruction !== 8'h00 || instr_fault !== 1'b1)
                begin errors++; $display("FAIL fault_pc_%h got v=%b d=%h f=%b exp v=1 d=00 f=1", addrs[i], instr_valid, instruction, instr_fault); end
        end
        pc_valid = 0; tick();
    endtask

    task automatic test_stall();
        instr_ready = 0; pc_valid = 1; pc = 8'd1; tick();
        pc = 8'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (pc_ready !== 1'b0 || instr_valid !== 1'b1 || instruction !== 8'h38 || instr_fault !== 1'b0)
                begin errors++; $display("FAIL stall[%0d] got rdy=%b v=%b d=%h f=%b exp rdy=0 v=1 d=38 f=0", i, pc_ready, instr_valid, instruction, instr_fault); end
            tick();
        end
        instr_ready = 1; #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL stall_release_rdy got %b exp 1", pc_ready); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instruction !== 8'h58 || instr_fault !== 1'b0)
            begin errors++; $display("FAIL stall_queued got v=%b d=%h f=%b exp v=1 d=58 f=0", instr_valid, instruction, instr_fault); end
        pc_valid = 0; tick();
    endtask

    task automatic test_overflow();
        logic [7:0] words [5];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
        d4_load_start = 1; tick(); d4_load_start = 0;
        for (int i = 0; i < 5; i++) begin
            d4_load_valid = 1; d4_load_data = words[i]; tick();
            if (i == 3) begin
                checks++; if (d4_load_overflow !== 1'b0 || d4_load_count !== 9'd4)
                    begin errors++; $display("FAIL ovf_at_full got o=%b c=%0d exp o=0 c=4", d4_load_overflow, d4_load_count); end
            end
        end
        d4_load_valid = 0;
        checks++; if (d4_load_count !== 9'd4 || d4_load_overflow !== 1'b1)
            begin errors++; $display("FAIL ovf_set got c=%0d o=%b exp c=4 o=1", d4_load_count, d4_load_overflow); end
        d4_load_done = 1; tick(); d4_load_done = 0;
        d4_pc_valid = 1; d4_pc = 8'd3; tick();
        checks++; if (d4_instruction !== 8'h44 || d4_instr_fault !== 1'b0)
            begin errors++; $display("FAIL ovf_mem3 got d=%h f=%b exp d=44 f=0", d4_instruction, d4_instr_fault); end
        d4_pc = 8'd4; tick();
        checks++; if (d4_instruction !== 8'h00 || d4_instr_fault !== 1'b1)
            begin errors++; $display("FAIL ovf_pc_depth got d=%h f=%b exp d=00 f=1", d4_instruction, d4_instr_fault); end
        d4_pc_valid = 0;
        d4_load_start = 1; tick(); d4_load_start = 0;
        checks++; if (d4_load_overflow !== 1'b0 || d4_load_count !== 9'd0 || d4_state !== 2'd1)
            begin errors++; $display("FAIL ovf_clear got o=%b c=%0d s=%0d exp o=0 c=0 s=1", d4_load_overflow, d4_load_count, d4_state); end
    endtask

    task automatic test_load_edges();
        load_start = 1; tick(); load_start = 0;
        load_valid = 1; load_data = 8'hAA; load_done = 1; tick();
        load_valid = 0; load_done = 0;
        checks++; if (state !== 2'd2 || load_count !== 9'd1)
            begin errors++; $display("FAIL valid_done got s=%0d c=%0d exp s=2 c=1", state, load_count); end
        pc_valid = 1; pc = 8'd0; tick(); pc_valid = 0;
        checks++; if (instruction !== 8'hAA || instr_fault !== 1'b0)
            begin errors++; $display("FAIL valid_done_fetch got d=%h f=%b exp d=AA f=0", instruction, instr_fault); end
        // Leave a response pending, then restart the load
        instr_ready = 0; pc_valid = 1; tick(); pc_valid = 0;
        load_start = 1; tick();
        checks++; if (instr_valid !== 1'b0 || state !== 2'd1)
            begin errors++; $display("FAIL restart_drop got v=%b s=%0d exp v=0 s=1", instr_valid, state); end
        load_done = 1; tick(); load_start = 0; load_done = 0;
        checks++; if (state !== 2'd1 || load_count !== 9'd0)
            begin errors++; $display("FAIL start_done got s=%0d c=%0d exp s=1 c=0", state, load_count); end
        instr_ready = 1;
    endtask

    task automatic test_reset_mid_run();
        load_valid = 1; load_data = 8'h5A; tick();
        load_valid = 0; load_done = 1; tick(); load_done = 0;
        instr_ready = 0; pc_valid = 1; pc = 8'd0; tick(); pc_valid = 0;
        checks++; if (instr_valid !== 1'b1 || instruction !== 8'h5A)
            begin errors++; $display("FAIL pre_reset got v=%b d=%h exp v=1 d=5A", instr_valid, instruction); end
        reset = 1; tick(); reset = 0;
        checks++; if (instr_valid !== 1'b0 || state !== 2'd0 || load_count !== 9'd0 || instruction !== 8'h00)
            begin errors++; $display("FAIL mid_reset got v=%b s=%0d c=%0d d=%h exp v=0 s=0 c=0 d=00", instr_valid, state, load_count, instruction); end
        load_start = 1; tick(); load_start = 0;
        load_done = 1; tick(); load_done = 0;
        checks++; if (state !== 2'd2 || load_count !== 9'd0)
            begin errors++; $display("FAIL empty_load got s=%0d c=%0d exp s=2 c=0", state, load_count); end
        instr_ready = 1; pc_valid = 1; pc = 8'd0; tick(); pc_valid = 0;
        checks++; if (instr_valid !== 1'b1 || instr_fault !== 1'b1 || instruction !== 8'h00)
            begin errors++; $display("FAIL empty_fetch got v=%b f=%b d=%h exp v=1 f=1 d=00", instr_valid, instr_fault, instruction); end
        tick();
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        load_start = 1; tick(); load_start = 0;
        load_valid = 1; load_data = 8'h5A; tick();
        load_valid = 0; load_done = 1; tick(); load_done = 0;
        pc_valid = 1; pc = 8'd0; tick(); pc_valid = 0;
        checks++; if (instr_parity_err !== 1'b0)
            begin errors++; $display("FAIL parity_clean got %b exp 0", instr_parity_err); end
        tick();
        dut.u_ram.r_mem[0] = dut.u_ram.r_mem[0] ^ 9'h001;
        pc_valid = 1; tick(); pc_valid = 0;
        checks++; if (instr_parity_err !== 1'b1 || instruction !== 8'h5B)
            begin errors++; $display("FAIL parity_flip got e=%b d=%h exp e=1 d=5B", instr_parity_err, instruction); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load_and_fetch();
        test_fault();
        test_stall();
        test_overflow();
        test_load_edges();
        test_reset_mid_run();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
